// File: rtl/hls_bus_arbiter_pkg.sv
// Shared constants and helpers for the two-requester HLS bus arbiter.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package hls_bus_pkg;

  localparam int NUM_PORTS = 2;
  localparam int PORT_IBUS = 0;
  localparam int PORT_DBUS = 1;
  localparam int TAG_W     = 1;

  typedef logic [TAG_W-1:0] tag_t;

  // Round-robin pick: a tie goes to the port that did not win last time.
  function automatic tag_t rr_pick(input logic [NUM_PORTS-1:0] elig, input tag_t last);
    if (elig == 2'b11) return ~last;
    return elig[PORT_IBUS] ? tag_t'(PORT_IBUS) : tag_t'(PORT_DBUS);
  endfunction

endpackage

// File: rtl/hls_bus_arbiter_if.sv
// One SimpleBus-style command/response channel.
// Latency: n/a (wires only); cmd_fire is derived combinationally.
// Backpressure: cmd_ready on commands; responses have none.
interface hls_bus_arbiter_if #(
  parameter int DW  = 32,
  parameter int DAW = 32
) ();
  logic           cmd_valid;
  logic           cmd_ready;
  logic [DAW-1:0] cmd_address;
  logic [DW-1:0]  cmd_data;
  logic [3:0]     cmd_mask;
  logic           cmd_write;
  logic           cmd_fire;
  logic           rsp_valid;
  logic [DW-1:0]  rsp_data;

  assign cmd_fire = cmd_valid & cmd_ready;

  modport master (
    output cmd_valid, cmd_address, cmd_data, cmd_mask, cmd_write,
    input  cmd_ready, cmd_fire, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_address, cmd_data, cmd_mask, cmd_write,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/hls_bus_arbiter_tag_fifo.sv
// Tag FIFO: remembers which requester issued each outstanding read.
// Latency: push visible at head one cycle later; head is combinational from rd_ptr.
// Backpressure: push ignored when full, pop ignored when empty; caller gates both.
module hls_tag_fifo
  import hls_bus_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  tag_t          push_tag,
  input  logic          pop,
  output tag_t          head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  tag_t          mem [DEPTH];
  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointers carry an extra MSB so full and empty are distinguishable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Tag storage; stale entries are harmless because the pointers gate them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_tag;
  end
endmodule

// File: rtl/hls_bus_arbiter.sv
// Round-robin share of one HLS command channel between iBus (port 0) and dBus (port 1).
// Latency: command path is combinational (zero cycles); responses route in the same cycle.
// Backpressure: bridge cmd_ready passes to the granted port; reads stall while the tag FIFO is full.
module hls_bus_arbiter
  import hls_bus_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  hls_bus_arbiter_if.slave                   s0,
  hls_bus_arbiter_if.slave                   s1,
  hls_bus_arbiter_if.master                  m,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               err_orphan_rsp
);
  logic [NUM_PORTS-1:0]       req_valid;
  logic [NUM_PORTS-1:0]       req_write;
  logic [NUM_PORTS-1:0]       eligible;
  logic [NUM_PORTS-1:0]       rdy_vec;
  logic [NUM_PORTS-1:0]       rsp_vec;
  logic [DATA_ADDR_WIDTH-1:0] req_addr [NUM_PORTS];
  logic [DATA_WIDTH-1:0]      req_data [NUM_PORTS];
  logic [3:0]                 req_mask [NUM_PORTS];
  tag_t                       grant;
  tag_t                       rr_last;
  tag_t                       head;
  logic                       any_elig;
  logic                       tag_full;
  logic                       tag_empty;
  logic                       rd_push;
  logic                       tag_pop;

  assign req_valid = {s1.cmd_valid, s0.cmd_valid};
  assign req_write = {s1.cmd_write, s0.cmd_write};
  assign req_addr[0] = s0.cmd_address;
  assign req_addr[1] = s1.cmd_address;
  assign req_data[0] = s0.cmd_data;
  assign req_data[1] = s1.cmd_data;
  assign req_mask[0] = s0.cmd_mask;
  assign req_mask[1] = s1.cmd_mask;

  // Eligibility and grant: reads sit out while the registered tag count is full.
  always_comb begin
    eligible = req_valid & (req_write | {NUM_PORTS{~tag_full}});
    any_elig = |eligible;
    grant    = rr_pick(eligible, rr_last);
  end

  assign m.cmd_valid   = any_elig & ~rst;
  assign m.cmd_address = req_addr[grant];
  assign m.cmd_data    = req_data[grant];
  assign m.cmd_mask    = req_mask[grant];
  assign m.cmd_write   = req_write[grant];

  // Only the granted port sees the bridge's ready.
  always_comb begin
    rdy_vec = '0;
    if (any_elig && m.cmd_ready && !rst) rdy_vec[grant] = 1'b1;
  end

  assign s0.cmd_ready = rdy_vec[0];
  assign s1.cmd_ready = rdy_vec[1];

  // Round-robin history advances only when a command is actually taken.
  always_ff @(posedge clk) begin
    if (rst) rr_last <= tag_t'(PORT_DBUS);
    else if (m.cmd_fire) rr_last <= grant;
  end

  assign rd_push = m.cmd_fire & ~m.cmd_write;
  assign tag_pop = m.rsp_valid & ~tag_empty & ~rst;

  hls_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (rd_push),
    .push_tag (grant),
    .pop      (tag_pop),
    .head     (head),
    .full     (tag_full),
    .empty    (tag_empty),
    .count    (outstanding)
  );

  // Route each in-order response to the requester recorded at the FIFO head.
  always_comb begin
    rsp_vec = '0;
    if (tag_pop) rsp_vec[head] = 1'b1;
  end

  assign s0.rsp_valid = rsp_vec[0];
  assign s1.rsp_valid = rsp_vec[1];
  assign s0.rsp_data  = m.rsp_data;
  assign s1.rsp_data  = m.rsp_data;

  // Sticky flag for a response arriving with nothing outstanding.
  always_ff @(posedge clk) begin
    if (rst) err_orphan_rsp <= 1'b0;
    else if (m.rsp_valid && tag_empty) err_orphan_rsp <= 1'b1;
  end
endmodule
